// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, bit helpers, the sigma/Sigma/Ch/Maj
// functions, round constants K and the initial hash value.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ROUNDS = 64;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t shr(input word_t x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// One step of the SHA-256 message expansion: the 4-operand modular sum that
// produces the next schedule word from the sliding window taps.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] w_new
);

  always_comb begin
    w_new = sig1(w14) + w9 + sig0(w1) + w0;
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: takes one padded 512-bit block and streams
// W0..W63 through a 16-word sliding window, one word per accepted beat.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  output logic [31:0]  wt_o,
  output logic         wt_valid_o,
  input  logic         wt_ready_i,
  output logic [5:0]   wt_idx_o,
  output logic         wt_last_o
);

  typedef enum logic {IDLE, RUN} sched_state_t;

  sched_state_t state_q, state_d;
  word_t        win_q [16];
  word_t        blk_words [16];
  word_t        w_new;
  logic [5:0]   t_q, t_d;
  logic         rdy_q, valid_q, last_q;
  logic         accept, beat;

  sha256_w_expand u_expand (
    .w0    (win_q[0]),
    .w1    (win_q[1]),
    .w9    (win_q[9]),
    .w14   (win_q[14]),
    .w_new (w_new)
  );

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      blk_words[i] = blk_data_i[32*(15-i) +: 32];
    end
  end

  // Ready is a flop rather than a state decode so that it stays low through
  // reset and rises only on the first edge after release.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    accept  = (state_q == IDLE) && rdy_q && blk_valid_i;
    beat    = (state_q == RUN) && wt_ready_i;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          t_d     = '0;
        end
      end
      RUN: begin
        if (beat) begin
          t_d = t_q + 6'd1;
          if (t_q == 6'd63) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      rdy_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      rdy_q   <= (state_d == IDLE);
      valid_q <= (state_d == RUN);
      last_q  <= (state_d == RUN) && (t_d == 6'd63);
      if (accept) begin
        for (int unsigned i = 0; i < 16; i++) begin
          win_q[i] <= blk_words[i];
        end
      end else if (beat) begin
        for (int unsigned i = 0; i < 15; i++) begin
          win_q[i] <= win_q[i+1];
        end
        win_q[15] <= w_new;
      end
    end
  end

  assign blk_ready_o = rdy_q;
  assign wt_o        = win_q[0];
  assign wt_valid_o  = valid_q;
  assign wt_idx_o    = t_q;
  assign wt_last_o   = last_q;

endmodule
